// File: rtl/aes_byte_loader_if.sv
// Byte-stream input and parallel key/block output bundle for aes_byte_loader.
// slave is the loader side; master is the upstream source plus downstream sink.
interface aes_byte_loader_if #(
  parameter int NK = 4
) ();
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              load_key;
  logic              abort;
  logic              out_valid;
  logic              out_ready;
  logic [32*NK-1:0]  key_out;
  logic [127:0]      data_out;

  modport slave (
    input  in_valid, in_data, load_key, abort, out_ready,
    output in_ready, out_valid, key_out, data_out
  );

  modport master (
    output in_valid, in_data, load_key, abort, out_ready,
    input  in_ready, out_valid, key_out, data_out
  );
endinterface

// File: rtl/aes_byte_loader.sv
// Assembles a cipher key and one 128-bit block from a byte stream, MSB first,
// and holds them for the AES core stage until downstream takes the frame.
module aes_byte_loader #(
  parameter int NK = 4
) (
  input  logic                clk,
  input  logic                reset,
  aes_byte_loader_if.slave    bus,
  output logic                key_loaded,
  output logic                busy
);
  localparam int KEY_BYTES = 4 * NK;
  localparam int KW        = 32 * NK;
  localparam int CNT_W     = $clog2(KEY_BYTES);

  generate
    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
      $fatal(1, "aes_byte_loader: NK must be 4, 6 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, KEY, DATA, HOLD} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic [KW-1:0]      key_q;
  logic [127:0]       data_q;
  logic               in_ready, accept, key_start, key_last, data_last;

  assign accept    = bus.in_valid && in_ready;
  // A frame opens with key bytes when asked to, or when no complete key is held.
  assign key_start = accept && (state == IDLE) && (bus.load_key || !key_loaded);
  assign key_last  = (count == CNT_W'(KEY_BYTES - 1));
  assign data_last = (count == CNT_W'(15));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = key_start ? KEY : DATA;
        KEY:     if (accept && key_last) state_nxt = DATA;
        DATA:    if (accept && data_last) state_nxt = HOLD;
        HOLD:    if (bus.out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready      = (state != HOLD) && !bus.abort;
    bus.in_ready  = in_ready;
    bus.out_valid = (state == HOLD);
    busy          = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      key_loaded <= 1'b0;
    end else if (bus.abort) begin
      count <= '0;
      if (state == KEY) key_loaded <= 1'b0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          count <= CNT_W'(1);
          if (key_start) key_loaded <= 1'b0;
        end
        KEY: begin
          if (key_last) begin
            count      <= '0;
            key_loaded <= 1'b1;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        DATA:    count <= data_last ? '0 : count + CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Left shift puts the first byte of each field in the top byte lane.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q  <= '0;
      data_q <= '0;
    end else if (accept) begin
      if (key_start || state == KEY) key_q  <= {key_q[KW-9:0], bus.in_data};
      else                           data_q <= {data_q[119:0], bus.in_data};
    end
  end

  assign bus.key_out  = key_q;
  assign bus.data_out = data_q;
endmodule

// File: tb/tb_aes_byte_loader.sv
// Frame-level bench for aes_byte_loader at NK=4 and NK=8 with a result queue
// checked at each downstream handshake.
module tb_aes_byte_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       sel8 = 1'b0;
  logic       in_valid = 1'b0, load_key = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       kl4, kl8, busy4, busy8;

  aes_byte_loader_if #(.NK(4)) b4 ();
  aes_byte_loader_if #(.NK(8)) b8 ();

  assign b4.in_valid  = in_valid & ~sel8;
  assign b4.in_data   = in_data;
  assign b4.load_key  = load_key;
  assign b4.abort     = abort & ~sel8;
  assign b4.out_ready = out_ready & ~sel8;
  assign b8.in_valid  = in_valid & sel8;
  assign b8.in_data   = in_data;
  assign b8.load_key  = load_key;
  assign b8.abort     = abort & sel8;
  assign b8.out_ready = out_ready & sel8;

  aes_byte_loader #(.NK(4)) dut4 (.clk(clk), .reset(reset), .bus(b4.slave), .key_loaded(kl4), .busy(busy4));
  aes_byte_loader #(.NK(8)) dut8 (.clk(clk), .reset(reset), .bus(b8.slave), .key_loaded(kl8), .busy(busy8));

  logic         in_ready_m, out_valid_m, key_loaded_m, busy_m;
  logic [255:0] key_m, data_m;
  assign in_ready_m   = sel8 ? b8.in_ready  : b4.in_ready;
  assign out_valid_m  = sel8 ? b8.out_valid : b4.out_valid;
  assign key_loaded_m = sel8 ? kl8 : kl4;
  assign busy_m       = sel8 ? busy8 : busy4;
  assign key_m        = sel8 ? b8.key_out : {128'd0, b4.key_out};
  assign data_m       = {128'd0, (sel8 ? b8.data_out : b4.data_out)};

  typedef struct {
    logic         nk8;
    logic         lk;
    logic [255:0] key;
    logic [127:0] data;
    logic [255:0] exp_key;
  } vec_t;

  typedef struct {
    logic [255:0] key;
    logic [255:0] data;
  } exp_t;

  vec_t vecs [6];
  exp_t sb [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [255:0] K0 = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K2 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K3 = 256'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [255:0] K8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  task automatic checkw(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic lk);
    logic rdy;
    int   waitc;
    rdy   = 1'b0;
    waitc = 0;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
    in_data  = b;
    load_key = lk;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = in_ready_m;
      @(posedge clk);
      waitc++;
    end while (!rdy && waitc < 50);
    #1;
    in_valid = 1'b0;
    if (!rdy) check1("accept_timeout", rdy, 1'b1);
  endtask

  task automatic send_frame(input logic lk, input int n_key, input logic [255:0] key,
                            input logic [127:0] data);
    for (int i = 0; i < n_key + 16; i++) begin
      logic [7:0] b;
      logic       lkb;
      if (i < n_key) b = key[8*(n_key-1-i) +: 8];
      else           b = data[8*(15-(i-n_key)) +: 8];
      lkb = (i == 0) ? lk : 1'($urandom_range(0, 1));
      if (i == n_key + 15) check1("out_valid_early", out_valid_m, 1'b0);
      send_byte(b, lkb);
      if (i == 0) check1("busy_in_frame", busy_m, 1'b1);
    end
  endtask

  task automatic check_hold();
    check1("out_valid_rise", out_valid_m, 1'b1);
    check1("in_ready_hold", in_ready_m, 1'b0);
    check1("key_loaded_hold", key_loaded_m, 1'b1);
  endtask

  task automatic release_frame();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check1("out_valid_fall", out_valid_m, 1'b0);
    check1("in_ready_after", in_ready_m, 1'b1);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && out_valid_m && out_ready) begin
      if (sb.size() == 0) begin
        check1("sb_underflow", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        checkw("key_out", key_m, e.key);
        checkw("data_out", data_m, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, K0, 128'h00112233445566778899aabbccddeeff, K0};
    vecs[1] = '{1'b0, 1'b0, '0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, K0};
    vecs[2] = '{1'b0, 1'b1, K2, 128'h3243f6a8885a308d313198a2e0370734, K2};
    vecs[3] = '{1'b0, 1'b0, '0, {128{1'b1}}, K2};
    vecs[4] = '{1'b1, 1'b1, K8, 128'h00112233445566778899aabbccddeeff, K8};
    vecs[5] = '{1'b1, 1'b0, '0, 128'h0, K8};

    repeat (2) @(posedge clk);
    #1;
    check1("rst_in_ready", in_ready_m, 1'b1);
    check1("rst_out_valid", out_valid_m, 1'b0);
    check1("rst_busy", busy_m, 1'b0);
    check1("rst_key_loaded", key_loaded_m, 1'b0);
    checkw("rst_key_out", key_m, '0);
    checkw("rst_data_out", data_m, '0);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      int nkey;
      sel8 = vecs[i].nk8;
      nkey = vecs[i].lk ? (vecs[i].nk8 ? 32 : 16) : 0;
      sb.push_back('{vecs[i].exp_key, {128'd0, vecs[i].data}});
      send_frame(vecs[i].lk, nkey, vecs[i].key, vecs[i].data);
      check_hold();
      if (i == 0) begin
        in_valid = 1'b1;
        in_data  = 8'haa;
        repeat (10) begin
          @(negedge clk);
          check1("bp_in_ready", in_ready_m, 1'b0);
          @(posedge clk);
          #1;
          check1("bp_out_valid", out_valid_m, 1'b1);
          checkw("bp_data_stable", data_m, {128'd0, vecs[0].data});
          checkw("bp_key_stable", key_m, K0);
        end
      end
      release_frame();
    end

    // abort while holding a frame drops it but keeps the key
    sel8 = 1'b0;
    send_frame(1'b0, 0, '0, 128'hdeadbeefdeadbeefdeadbeefdeadbeef);
    check_hold();
    abort = 1'b1;
    @(negedge clk);
    check1("abort_in_ready", in_ready_m, 1'b0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    check1("abort_hold_out_valid", out_valid_m, 1'b0);
    check1("abort_hold_busy", busy_m, 1'b0);
    check1("abort_hold_key_loaded", key_loaded_m, 1'b1);
    sb.push_back('{K2, 256'h0123456789abcdef0123456789abcdef});
    send_frame(1'b0, 0, '0, 128'h0123456789abcdef0123456789abcdef);
    check_hold();
    release_frame();

    // abort part-way through a key load
    for (int i = 0; i < 7; i++) send_byte(8'h50 + 8'(i), (i == 0));
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check1("abort_key_busy", busy_m, 1'b0);
    check1("abort_key_loaded", key_loaded_m, 1'b0);
    check1("abort_key_out_valid", out_valid_m, 1'b0);
    sb.push_back('{K3, 256'hfedcba9876543210fedcba9876543210});
    send_frame(1'b0, 16, K3, 128'hfedcba9876543210fedcba9876543210);
    check_hold();
    release_frame();

    // asynchronous reset between clock edges in the middle of a data phase
    for (int i = 0; i < 5; i++) send_byte(8'h11 * 8'(i), 1'b0);
    #3;
    reset = 1'b0;
    #1;
    check1("arst_out_valid", out_valid_m, 1'b0);
    check1("arst_busy", busy_m, 1'b0);
    check1("arst_key_loaded", key_loaded_m, 1'b0);
    check1("arst_in_ready", in_ready_m, 1'b1);
    checkw("arst_key_out", key_m, '0);
    checkw("arst_data_out", data_m, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb.push_back('{K2, 256'h3243f6a8885a308d313198a2e0370734});
    send_frame(1'b0, 16, K2, 128'h3243f6a8885a308d313198a2e0370734);
    check_hold();
    release_frame();

    repeat (2) @(posedge clk);
    checkw("sb_drained", 256'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
